// File: rtl/bus8_arbiter.sv
// bus8_arbiter
//   Two-requester round-robin arbiter in front of one Bus8 slave port. Each grant
//   issues a single-cycle bus command; a read response (or a timeout) is routed
//   back to the requester that owned the command.
//
// Ports
//   i_Bus_Clk, i_Bus_Rst_L  : clock, asynchronous active-low reset
//   i_Req_Valid[1:0]        : requester n has a transaction pending
//   i_Req_Wr_Rd_n[1:0]      : requester n direction (1 = write, 0 = read)
//   i_Req_Addr8             : requester n address at [n*ADDR_WIDTH +: ADDR_WIDTH]
//   i_Req_Wr_Data[15:0]     : requester n write data at [n*8 +: 8]
//   o_Req_Accept[1:0]       : pulse, requester n's command is on the bus
//   o_Req_Rd_DV[1:0]        : pulse, o_Req_Rd_Data valid for requester n
//   o_Req_Rd_Data[7:0]      : shared read data (0x00 after a timeout)
//   o_Req_Timeout[1:0]      : pulse, requester n's read got no response
//   o_Bus_CS, o_Bus_Wr_Rd_n, o_Bus_Addr8, o_Bus_Wr_Data : bus command to slave
//   i_Bus_Rd_Data, i_Bus_Rd_DV                          : slave read response
module bus8_arbiter #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic                    i_Bus_Clk,
    input  logic                    i_Bus_Rst_L,
    input  logic [1:0]              i_Req_Valid,
    input  logic [1:0]              i_Req_Wr_Rd_n,
    input  logic [2*ADDR_WIDTH-1:0] i_Req_Addr8,
    input  logic [15:0]             i_Req_Wr_Data,
    output logic [1:0]              o_Req_Accept,
    output logic [1:0]              o_Req_Rd_DV,
    output logic [7:0]              o_Req_Rd_Data,
    output logic [1:0]              o_Req_Timeout,
    output logic                    o_Bus_CS,
    output logic                    o_Bus_Wr_Rd_n,
    output logic [ADDR_WIDTH-1:0]   o_Bus_Addr8,
    output logic [7:0]              o_Bus_Wr_Data,
    input  logic [7:0]              i_Bus_Rd_Data,
    input  logic                    i_Bus_Rd_DV
);

    localparam int unsigned CntWidth = $clog2(TIMEOUT + 1);
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StCmd,
        StWaitRd
    } state_e;

    state_e                r_state;
    // Grant of the current (or most recent) transaction; doubles as the
    // round-robin history, so it also picks the owner of a read response.
    logic                  r_last_grant;
    logic [CntWidth-1:0]   r_cnt;

    logic                  r_req_accept_0;
    logic                  r_req_accept_1;
    logic [1:0]            r_req_rd_dv;
    logic [7:0]            r_req_rd_data;
    logic [1:0]            r_req_timeout;
    logic                  r_bus_cs;
    logic                  r_bus_wr_rd_n;
    logic [ADDR_WIDTH-1:0] r_bus_addr8;
    logic [7:0]            r_bus_wr_data;

    logic                  w_any_valid;
    logic                  w_grant;
    logic [1:0]            w_owner_oh;
    logic                  w_sel_wr_rd_n;
    logic [ADDR_WIDTH-1:0] w_sel_addr8;
    logic [7:0]            w_sel_wr_data;

    assign w_any_valid = |i_Req_Valid;

    // Requester 1 wins when it is alone, or when both are valid and
    // requester 0 held the previous grant.
    assign w_grant = i_Req_Valid[1] & (~i_Req_Valid[0] | ~r_last_grant);

    assign w_owner_oh    = r_last_grant ? 2'b10 : 2'b01;
    assign w_sel_wr_rd_n = w_grant ? i_Req_Wr_Rd_n[1] : i_Req_Wr_Rd_n[0];
    assign w_sel_addr8   = w_grant ? i_Req_Addr8[ADDR_WIDTH +: ADDR_WIDTH]
                                   : i_Req_Addr8[0 +: ADDR_WIDTH];
    assign w_sel_wr_data = w_grant ? i_Req_Wr_Data[15:8] : i_Req_Wr_Data[7:0];

    always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
        if (!i_Bus_Rst_L) begin
            r_state        <= StIdle;
            r_last_grant   <= 1'b1;
            r_cnt          <= '0;
            r_req_accept_0 <= 1'b0;
            r_req_accept_1 <= 1'b0;
            r_req_rd_dv    <= 2'b00;
            r_req_rd_data  <= 8'h00;
            r_req_timeout  <= 2'b00;
            r_bus_cs       <= 1'b0;
            r_bus_wr_rd_n  <= 1'b0;
            r_bus_addr8    <= '0;
            r_bus_wr_data  <= 8'h00;
        end else begin
            // Pulse outputs default low; bus fields hold their last values.
            r_req_accept_0 <= 1'b0;
            r_req_accept_1 <= 1'b0;
            r_req_rd_dv    <= 2'b00;
            r_req_timeout  <= 2'b00;
            r_bus_cs       <= 1'b0;

            case (r_state)
                StIdle: begin
                    if (w_any_valid) begin
                        r_last_grant   <= w_grant;
                        r_bus_wr_rd_n  <= w_sel_wr_rd_n;
                        r_bus_addr8    <= w_sel_addr8;
                        r_bus_wr_data  <= w_sel_wr_data;
                        r_bus_cs       <= 1'b1;
                        r_req_accept_0 <= ~w_grant;
                        r_req_accept_1 <= w_grant;
                        r_state        <= StCmd;
                    end
                end

                StCmd: begin
                    r_cnt   <= '0;
                    r_state <= r_bus_wr_rd_n ? StIdle : StWaitRd;
                end

                StWaitRd: begin
                    r_cnt <= r_cnt + CntWidth'(1);
                    // A response on the boundary cycle still counts as data.
                    if (i_Bus_Rd_DV) begin
                        r_req_rd_data <= i_Bus_Rd_Data;
                        r_req_rd_dv   <= w_owner_oh;
                        r_state       <= StIdle;
                    end else if (r_cnt == CntLast) begin
                        r_req_rd_data <= 8'h00;
                        r_req_timeout <= w_owner_oh;
                        r_state       <= StIdle;
                    end
                end

                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_Req_Accept  = {r_req_accept_1, r_req_accept_0};
    assign o_Req_Rd_DV   = r_req_rd_dv;
    assign o_Req_Rd_Data = r_req_rd_data;
    assign o_Req_Timeout = r_req_timeout;
    assign o_Bus_CS      = r_bus_cs;
    assign o_Bus_Wr_Rd_n = r_bus_wr_rd_n;
    assign o_Bus_Addr8   = r_bus_addr8;
    assign o_Bus_Wr_Data = r_bus_wr_data;

endmodule

// File: tb/tb_bus8_arbiter.sv
// tb_bus8_arbiter
//   Directed bench for bus8_arbiter: a small DPRAM-like slave model (DV one
//   cycle after a read CS, switchable off) plus a manual DV injector for stray
//   and boundary responses.
module tb_bus8_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_wr_rd_n;
    logic [15:0] req_addr8;
    logic [15:0] req_wr_data;
    logic [1:0]  req_accept;
    logic [1:0]  req_rd_dv;
    logic [7:0]  req_rd_data;
    logic [1:0]  req_timeout;
    logic        bus_cs;
    logic        bus_wr_rd_n;
    logic [7:0]  bus_addr8;
    logic [7:0]  bus_wr_data;
    logic [7:0]  bus_rd_data;
    logic        bus_rd_dv;

    // Slave model and manual injector
    logic [7:0]  mem [256];
    logic        slave_en;
    logic        mdl_dv;
    logic [7:0]  mdl_data;
    logic        inj_dv;
    logic [7:0]  inj_data;

    int n_checks;
    int n_errors;
    int n_viol;
    logic prev_cs;

    bus8_arbiter #(
        .ADDR_WIDTH (8),
        .TIMEOUT    (15)
    ) u_dut (
        .i_Bus_Clk     (clk),
        .i_Bus_Rst_L   (rst_n),
        .i_Req_Valid   (req_valid),
        .i_Req_Wr_Rd_n (req_wr_rd_n),
        .i_Req_Addr8   (req_addr8),
        .i_Req_Wr_Data (req_wr_data),
        .o_Req_Accept  (req_accept),
        .o_Req_Rd_DV   (req_rd_dv),
        .o_Req_Rd_Data (req_rd_data),
        .o_Req_Timeout (req_timeout),
        .o_Bus_CS      (bus_cs),
        .o_Bus_Wr_Rd_n (bus_wr_rd_n),
        .o_Bus_Addr8   (bus_addr8),
        .o_Bus_Wr_Data (bus_wr_data),
        .i_Bus_Rd_Data (bus_rd_data),
        .i_Bus_Rd_DV   (bus_rd_dv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus_rd_dv   = mdl_dv | inj_dv;
    assign bus_rd_data = inj_dv ? inj_data : mdl_data;

    always @(posedge clk) begin
        mdl_dv <= 1'b0;
        if (bus_cs) begin
            if (bus_wr_rd_n) begin
                mem[bus_addr8] <= bus_wr_data;
            end else if (slave_en) begin
                mdl_dv   <= 1'b1;
                mdl_data <= mem[bus_addr8];
            end
        end
    end

    // Protocol monitor: no back-to-back CS, at most one pulse bit per cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_cs = 1'b0;
        end else begin
            if (bus_cs && prev_cs) n_viol++;
            if ($countones({req_accept, req_rd_dv, req_timeout}) > 1) n_viol++;
            prev_cs = bus_cs;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] all_outs();
        return {req_accept, req_rd_dv, req_rd_data, req_timeout,
                bus_cs, bus_wr_rd_n, bus_addr8, bus_wr_data};
    endfunction

    logic [1:0] exp_rr [7];
    logic [1:0] seen;

    initial begin
        n_checks = 0;
        n_errors = 0;
        n_viol   = 0;
        prev_cs  = 1'b0;
        mdl_dv   = 1'b0;
        mdl_data = 8'h00;
        rst_n       = 1'b0;
        req_valid   = 2'b00;
        req_wr_rd_n = 2'b00;
        req_addr8   = 16'h0000;
        req_wr_data = 16'h0000;
        inj_dv      = 1'b0;
        inj_data    = 8'h00;
        slave_en    = 1'b1;
        exp_rr = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};

        tick();
        tick();
        check("reset_outs", all_outs(), 32'h0);
        rst_n = 1'b1;
        tick();

        // Requester 0 writes 0xA5 to 0x10
        req_valid   = 2'b01;
        req_wr_rd_n = 2'b01;
        req_addr8   = 16'h0010;
        req_wr_data = 16'h00A5;
        tick();
        check("wr_cs", bus_cs, 1);
        check("wr_dir", bus_wr_rd_n, 1);
        check("wr_addr", bus_addr8, 8'h10);
        check("wr_data", bus_wr_data, 8'hA5);
        check("wr_accept", req_accept, 2'b01);
        req_valid = 2'b00;
        tick();
        check("wr_cs_single", bus_cs, 0);

        // Requester 1 reads 0x10
        req_valid   = 2'b10;
        req_wr_rd_n = 2'b00;
        req_addr8   = 16'h1000;
        tick();
        check("rd_accept", req_accept, 2'b10);
        check("rd_dir", bus_wr_rd_n, 0);
        check("rd_addr", bus_addr8, 8'h10);
        req_valid = 2'b00;
        tick();
        check("rd_dv_early", req_rd_dv, 2'b00);
        tick();
        check("rd_dv", req_rd_dv, 2'b10);
        check("rd_data", req_rd_data, 8'hA5);
        check("rd_no_timeout", req_timeout, 2'b00);

        // Both requesters write twice each, holding Valid
        req_valid   = 2'b11;
        req_wr_rd_n = 2'b11;
        req_addr8   = 16'h2120;
        req_wr_data = 16'hB1B0;
        begin
            int n0;
            int n1;
            n0 = 0;
            n1 = 0;
            for (int i = 0; i < 7; i++) begin
                tick();
                check("rr_accept", req_accept, exp_rr[i]);
                check("rr_cs", bus_cs, (exp_rr[i] != 2'b00) ? 1 : 0);
                if (exp_rr[i] == 2'b01) begin
                    check("rr_addr0", bus_addr8, 8'h20);
                    n0++;
                    if (n0 == 2) req_valid[0] = 1'b0;
                end
                if (exp_rr[i] == 2'b10) begin
                    check("rr_addr1", bus_addr8, 8'h21);
                    n1++;
                    if (n1 == 2) req_valid[1] = 1'b0;
                end
            end
        end
        tick();

        // Read timeout, silent slave
        slave_en    = 1'b0;
        req_valid   = 2'b01;
        req_wr_rd_n = 2'b00;
        req_addr8   = 16'h0030;
        for (int i = 1; i <= 17; i++) begin
            tick();
            if (i == 1) req_valid = 2'b00;
            check("to_pulse", req_timeout, (i == 17) ? 2'b01 : 2'b00);
            if (i == 17) begin
                check("to_data", req_rd_data, 8'h00);
                check("to_no_dv", req_rd_dv, 2'b00);
            end
        end
        slave_en  = 1'b1;
        req_valid = 2'b10;
        req_addr8 = 16'h1000;
        tick();
        check("after_to_accept", req_accept, 2'b10);
        req_valid = 2'b00;
        tick();
        tick();
        check("after_to_dv", req_rd_dv, 2'b10);
        check("after_to_data", req_rd_data, 8'hA5);

        // Stray DV in IDLE is dropped
        inj_dv   = 1'b1;
        inj_data = 8'h5A;
        tick();
        inj_dv = 1'b0;
        check("stray_dv", req_rd_dv, 2'b00);
        tick();
        check("stray_dv2", req_rd_dv, 2'b00);
        check("stray_data", req_rd_data, 8'hA5);
        check("stray_timeout", req_timeout, 2'b00);

        // DV on the timeout boundary wins
        slave_en    = 1'b0;
        req_valid   = 2'b01;
        req_wr_rd_n = 2'b00;
        req_addr8   = 16'h0040;
        for (int i = 1; i <= 18; i++) begin
            tick();
            if (i == 1) req_valid = 2'b00;
            if (i == 16) begin
                check("edge_pre_dv", req_rd_dv, 2'b00);
                inj_dv   = 1'b1;
                inj_data = 8'h3C;
            end
            if (i == 17) begin
                inj_dv = 1'b0;
                check("edge_dv", req_rd_dv, 2'b01);
                check("edge_data", req_rd_data, 8'h3C);
                check("edge_no_to", req_timeout, 2'b00);
            end
            if (i == 18) check("edge_no_to_late", req_timeout, 2'b00);
        end

        // Reset during WAIT_RD
        req_valid   = 2'b01;
        req_wr_rd_n = 2'b00;
        req_addr8   = 16'h0050;
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("rst_async", all_outs(), 32'h0);
        tick();
        rst_n = 1'b1;
        seen  = 2'b00;
        for (int i = 0; i < 20; i++) begin
            tick();
            seen = seen | req_rd_dv | req_timeout;
        end
        check("rst_no_pulse", seen, 2'b00);
        req_valid   = 2'b11;
        req_wr_rd_n = 2'b11;
        req_addr8   = 16'h6160;
        tick();
        check("rst_rr_first", req_accept, 2'b01);
        check("rst_rr_addr", bus_addr8, 8'h60);
        req_valid = 2'b00;
        tick();
        tick();

        check("protocol_viol", n_viol, 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
